mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data-memory requester.
- The data requester is driven by the control unit's dcuREN/dcuWEN decode.
- Sits between the datapath (PC fetch path and MEM stage) and the RAM model.
- Fixed data priority by default, with a streak counter that forces an instruction grant so fetch cannot starve.
- Each access is a multi-cycle request/ready transaction; the requester is stalled via its wait output until the RAM signals ready.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- MAX_DSTREAK, 4, number of consecutive data grants after which a pending instruction request wins the next arbitration. Range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- iREN  input  1  instruction read request.
- iaddr  input  ADDR_W  instruction address.
- iwait  output  1  instruction stall; 0 only in the cycle iload is valid.
- iload  output  DATA_W  fetched instruction word.
- dREN  input  1  data read request (from dcuREN).
- dWEN  input  1  data write request (from dcuWEN).
- daddr  input  ADDR_W  data address.
- dstore  input  DATA_W  write data.
- dwait  output  1  data stall; 0 only in the completion cycle.
- dload  output  DATA_W  read data.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  DATA_W  RAM write data.
- ramload  input  DATA_W  RAM read data.
- ram_ready  input  1  RAM access complete; ramload is valid this cycle.

Behaviour:
- FSM states: IDLE, IACC, DACC.
- Reset (RST=1 at a clock edge):
  - state=IDLE, dstreak=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=dwait=1, iload=dload=0.
- Reset mid-access: the transaction is abandoned, strobes drop the next cycle, and no ready pulse is issued to either requester.
- Request definitions: ireq = iREN; dreq = dREN | dWEN.
- dREN and dWEN both high is illegal; treat it as a write (ramWEN=1, ramREN=0).
- Arbitration (evaluated in IDLE only):
  - If dreq and (!ireq or dstreak < MAX_DSTREAK): go to DACC and latch daddr, dstore, and op type.
  - Else if ireq: go to IACC and latch iaddr.
  - Else stay in IDLE.
- Request capture: address, data and op are registered at grant. Requester input changes during an access are ignored.
- Strobes: in IACC/DACC, ramaddr/ramstore/ramREN/ramWEN are driven from the latched values. Strobes are registered, so they are asserted the cycle after grant.
- Completion in IACC, on ram_ready=1:
  - Same cycle (combinational from ram_ready): iwait=0, iload=ramload.
  - Next cycle: state returns to IDLE, dstreak=0.
- Completion in DACC, on ram_ready=1:
  - Same cycle: dwait=0; dload=ramload for reads, dload unchanged for writes.
  - Next cycle: state returns to IDLE.
  - dstreak increments if ireq was high at grant, otherwise resets to 0. It saturates at 15.
- Turnaround: exactly one IDLE cycle between back-to-back accesses, with strobes low in that cycle.
  - Minimum latency from request (in IDLE) to completion is 2 cycles with ram_ready=1 immediately.
- Outside its completion cycle each wait output is 1, including while idle with no request.
- ram_ready while in IDLE is ignored.
- The requester must hold its request until it sees wait=0. A request dropped before grant is simply not served.
- Simultaneous ireq and dreq with dstreak=MAX_DSTREAK: the instruction wins; dstreak resets when that access completes.

Test Plan:
- Fetch only: iREN=1, iaddr=0x100, ram_ready one cycle after ramREN, ramload=0x8C220004.
  - ramREN=1 with ramaddr=0x100 from cycle 1; iwait=0 and iload=0x8C220004 in cycle 2; strobes low in cycle 3.
- Data write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ram_ready after 3 cycles.
  - ramWEN=1, ramstore=0xDEADBEEF held 3 cycles; dwait=0 for exactly one cycle; ramREN=0 throughout.
- Contention: iREN and dREN both held high continuously, MAX_DSTREAK=4.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - Every access is separated by one IDLE cycle.
- Capture: daddr changes from 0x200 to 0x300 during DACC.
  - ramaddr stays 0x200 until completion.
- Reset mid-op: RST=1 while in DACC with ramWEN=1.
  - Next cycle ramWEN=0, dwait=1, state IDLE.
  - After RST=0 with dWEN still high, a fresh grant occurs.
- Illegal dREN=dWEN=1:
  - Only ramWEN asserted.
  - dload is unchanged at completion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one RAM port between the instruction-fetch requester and the data-memory requester.
// Data wins by default. A streak counter makes a pending fetch win after MAX_DSTREAK
// consecutive data grants that each had a fetch waiting, so fetch cannot starve.
// Every access is a request/ready transaction. The requester's wait output stays high
// until the RAM signals ready.
//
// Ports:
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   iREN, iaddr        instruction read request and address
//   iwait, iload       instruction stall (low only in the completion cycle) and fetched word
//   dREN, dWEN         data read / write request (both high is treated as a write)
//   daddr, dstore      data address and write data
//   dwait, dload       data stall (low only in the completion cycle) and read data
//   ramREN, ramWEN     registered RAM read / write strobes
//   ramaddr, ramstore  registered RAM address and write data
//   ramload, ram_ready RAM read data and access-complete flag

module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic              CLK,
   input  logic              RST,
   // instruction requester
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   // data requester
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   // RAM port
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready
);

   localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);
   localparam logic [3:0] StreakSat = 4'd15;

   typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

   state_e            state_q, state_d;
   logic [3:0]        dstreak_q, dstreak_d;
   logic              ireq_g_q, ireq_g_d;     // fetch was pending when the data access was granted
   logic              ram_ren_q, ram_ren_d;
   logic              ram_wen_q, ram_wen_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_store_q, ram_store_d;
   logic [DATA_W-1:0] iload_q, iload_d;
   logic [DATA_W-1:0] dload_q, dload_d;

   logic ireq, dreq;
   logic i_done, d_done;

   assign ireq = iREN;
   assign dreq = dREN | dWEN;

   always_comb begin
      state_d     = state_q;
      dstreak_d   = dstreak_q;
      ireq_g_d    = ireq_g_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      iload_d     = iload_q;
      dload_d     = dload_q;
      i_done      = 1'b0;
      d_done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Strobes are registered, so they appear the cycle after the grant.
            if (dreq && (!ireq || (dstreak_q < MaxStreak))) begin
               state_d     = StDacc;
               ireq_g_d    = ireq;
               ram_addr_d  = daddr;
               ram_store_d = dstore;
               ram_wen_d   = dWEN;    // dREN & dWEN together is treated as a write
               ram_ren_d   = ~dWEN;
            end else if (ireq) begin
               state_d    = StIacc;
               ram_addr_d = iaddr;
               ram_ren_d  = 1'b1;
               ram_wen_d  = 1'b0;
            end
         end
         StIacc: begin
            if (ram_ready) begin
               i_done    = 1'b1;
               state_d   = StIdle;
               dstreak_d = '0;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               iload_d   = ramload;
            end
         end
         StDacc: begin
            if (ram_ready) begin
               d_done    = 1'b1;
               state_d   = StIdle;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               if (!ram_wen_q) begin
                  dload_d = ramload;
               end
               if (ireq_g_q) begin
                  dstreak_d = (dstreak_q == StreakSat) ? StreakSat : dstreak_q + 4'd1;
               end else begin
                  dstreak_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A transaction abandoned by reset must not signal completion to its requester.
      if (RST) begin
         i_done = 1'b0;
         d_done = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         dstreak_q   <= '0;
         ireq_g_q    <= 1'b0;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         iload_q     <= '0;
         dload_q     <= '0;
      end else begin
         state_q     <= state_d;
         dstreak_q   <= dstreak_d;
         ireq_g_q    <= ireq_g_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         iload_q     <= iload_d;
         dload_q     <= dload_d;
      end
   end

   assign iwait    = ~i_done;
   assign iload    = i_done ? ramload : iload_q;
   assign dwait    = ~d_done;
   assign dload    = (d_done && !ram_wen_q) ? ramload : dload_q;
   assign ramREN   = ram_ren_q;
   assign ramWEN   = ram_wen_q;
   assign ramaddr  = ram_addr_q;
   assign ramstore = ram_store_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int MAXD = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN, dWEN;
   logic [31:0] daddr, dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore;
   logic [31:0] ramload   = 32'h0;
   logic        ram_ready = 1'b0;

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MAX_DSTREAK (MAXD)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iwait     (iwait),
      .iload     (iload),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dwait     (dwait),
      .dload     (dload),
      .ramREN    (ramREN),
      .ramWEN    (ramWEN),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ramload   (ramload),
      .ram_ready (ram_ready)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, act, exp);
   endtask

   // Move into the next cycle: just after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // RAM responder: ready after ready_lat cycles of an asserted strobe.
   int ready_lat   = 1;
   bit force_ready = 1'b0;
   int strobe_cnt  = 0;

   function automatic logic [31:0] ram_data(input logic [31:0] a);
      if (a == 32'h100) return 32'h8C22_0004;
      return a + 32'h1000_0000;
   endfunction

   initial forever begin
      @(posedge CLK);
      #1;
      if (ramREN || ramWEN) strobe_cnt++;
      else strobe_cnt = 0;
      ram_ready = (strobe_cnt == ready_lat) || force_ready;
      ramload   = ram_data(ramaddr);
   end

   // Behavioural model: one outstanding access, a grant rule and a streak count.
   bit          m_valid  = 1'b0;
   bit          m_busy   = 1'b0;
   bit          m_is_d   = 1'b0;
   bit          m_wr     = 1'b0;
   bit          m_ireq_g = 1'b0;
   int          m_streak = 0;
   logic [31:0] m_addr   = 32'h0;
   logic [31:0] m_store  = 32'h0;
   logic [31:0] m_iload  = 32'h0;
   logic [31:0] m_dload  = 32'h0;

   initial forever begin
      @(posedge CLK);
      if (RST) begin
         m_valid  = 1'b1;
         m_busy   = 1'b0;
         m_streak = 0;
         m_iload  = 32'h0;
         m_dload  = 32'h0;
      end else if (m_busy) begin
         if (ram_ready) begin
            if (m_is_d) begin
               if (!m_wr) m_dload = ramload;
               m_streak = m_ireq_g ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
            end else begin
               m_iload  = ramload;
               m_streak = 0;
            end
            m_busy = 1'b0;
         end
      end else if ((dREN || dWEN) && (!iREN || m_streak < MAXD)) begin
         m_busy   = 1'b1;
         m_is_d   = 1'b1;
         m_wr     = dWEN;
         m_addr   = daddr;
         m_store  = dstore;
         m_ireq_g = iREN;
      end else if (iREN) begin
         m_busy = 1'b1;
         m_is_d = 1'b0;
         m_wr   = 1'b0;
         m_addr = iaddr;
      end
   end

   // Every-cycle comparison against the model.
   bit c_idone, c_ddone;

   initial forever begin
      @(negedge CLK);
      if (m_valid) begin
         c_idone = m_busy && !m_is_d && ram_ready && !RST;
         c_ddone = m_busy && m_is_d && ram_ready && !RST;
         check("m_iwait", 32'(iwait), 32'(!c_idone));
         check("m_dwait", 32'(dwait), 32'(!c_ddone));
         check("m_iload", iload, c_idone ? ramload : m_iload);
         check("m_dload", dload, (c_ddone && !m_wr) ? ramload : m_dload);
         check("m_ramREN", 32'(ramREN), 32'(m_busy && !(m_is_d && m_wr)));
         check("m_ramWEN", 32'(ramWEN), 32'(m_busy && m_is_d && m_wr));
         if (m_busy) check("m_ramaddr", ramaddr, m_addr);
         if (m_busy && m_is_d && m_wr) check("m_ramstore", ramstore, m_store);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int    wen_n, ren_n, dw0_n, hi_n, b2b_n;
   bit    got, prev_hi;
   string grants;

   initial begin
      iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0; RST = 1;
      repeat (2) @(posedge CLK);
      #1 RST = 0;

      // Reset state
      @(negedge CLK);
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_dwait", 32'(dwait), 32'd1);
      check("rst_iload", iload, 32'h0);
      check("rst_dload", dload, 32'h0);
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_ramWEN", 32'(ramWEN), 32'd0);
      check("rst_ramaddr", ramaddr, 32'h0);
      check("rst_ramstore", ramstore, 32'h0);

      // Fetch only
      ready_lat = 2;
      step(); iREN = 1; iaddr = 32'h100;
      @(negedge CLK); check("f_c0_ramREN", 32'(ramREN), 32'd0);
      step(); @(negedge CLK);
      check("f_c1_ramREN", 32'(ramREN), 32'd1);
      check("f_c1_ramaddr", ramaddr, 32'h100);
      check("f_c1_iwait", 32'(iwait), 32'd1);
      step(); @(negedge CLK);
      check("f_c2_iwait", 32'(iwait), 32'd0);
      check("f_c2_iload", iload, 32'h8C22_0004);
      step(); iREN = 0; @(negedge CLK);
      check("f_c3_ramREN", 32'(ramREN), 32'd0);
      check("f_c3_iwait", 32'(iwait), 32'd1);

      // Data write, ready after 3 cycles
      ready_lat = 3;
      step(); dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
      wen_n = 0; ren_n = 0; dw0_n = 0; got = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (ramWEN) begin
            wen_n++;
            check("w_ramstore", ramstore, 32'hDEAD_BEEF);
         end
         if (ramREN) ren_n++;
         if (!dwait) begin dw0_n++; got = 1; end
         step();
         if (got) dWEN = 0;
      end
      check("w_wen_cycles", 32'(wen_n), 32'd3);
      check("w_dwait_low_cycles", 32'(dw0_n), 32'd1);
      check("w_ren_cycles", 32'(ren_n), 32'd0);

      // Contention with both requests held
      ready_lat = 1;
      iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h500;
      grants = ""; hi_n = 0; b2b_n = 0; prev_hi = 0;
      for (int k = 1; k <= 19; k++) begin
         step(); @(negedge CLK);
         if (ramREN || ramWEN) begin
            hi_n++;
            if (prev_hi) b2b_n++;
            grants = {grants, (ramaddr == 32'h500) ? "D" : "I"};
         end
         prev_hi = ramREN || ramWEN;
      end
      step(); iREN = 0; dREN = 0;
      check_str("c_grant_order", grants, "DDDDIDDDDI");
      check("c_access_count", 32'(hi_n), 32'd10);
      check("c_back_to_back", 32'(b2b_n), 32'd0);

      // Capture: address change during the access is ignored
      ready_lat = 3;
      step(); dREN = 1; daddr = 32'h200;
      step(); @(negedge CLK);
      check("cap_c1_ramaddr", ramaddr, 32'h200);
      daddr = 32'h300;
      step(); @(negedge CLK);
      check("cap_c2_ramaddr", ramaddr, 32'h200);
      step(); @(negedge CLK);
      check("cap_c3_dwait", 32'(dwait), 32'd0);
      check("cap_c3_ramaddr", ramaddr, 32'h200);
      check("cap_c3_dload", dload, 32'h1000_0200);
      step(); dREN = 0; @(negedge CLK);
      check("cap_c4_ramREN", 32'(ramREN), 32'd0);

      // Illegal dREN & dWEN: behaves as a write, dload untouched
      ready_lat = 2;
      step(); dREN = 1; dWEN = 1; daddr = 32'h700; dstore = 32'hCAFE_F00D;
      wen_n = 0; ren_n = 0; got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge CLK);
         if (ramWEN) wen_n++;
         if (ramREN) ren_n++;
         if (!dwait) begin
            got = 1;
            check("ill_dload_kept", dload, 32'h1000_0200);
         end
         step();
      end
      dREN = 0; dWEN = 0;
      check("ill_completed", 32'(got), 32'd1);
      check("ill_wen_cycles", 32'(wen_n), 32'd2);
      check("ill_ren_cycles", 32'(ren_n), 32'd0);

      // ram_ready in idle is ignored
      @(negedge CLK); force_ready = 1;
      for (int k = 0; k < 3; k++) begin
         step(); @(negedge CLK);
         check("idle_rdy_iwait", 32'(iwait), 32'd1);
         check("idle_rdy_dwait", 32'(dwait), 32'd1);
      end
      force_ready = 0;

      // Reset in the middle of a write
      ready_lat = 5;
      step(); dWEN = 1; daddr = 32'h600; dstore = 32'h1234_5678;
      step(); @(negedge CLK);
      check("rmo_c1_ramWEN", 32'(ramWEN), 32'd1);
      step(); RST = 1;
      step(); RST = 0; @(negedge CLK);
      check("rmo_c3_ramWEN", 32'(ramWEN), 32'd0);
      check("rmo_c3_dwait", 32'(dwait), 32'd1);
      check("rmo_c3_dload", dload, 32'h0);
      step(); @(negedge CLK);
      check("rmo_c4_ramWEN", 32'(ramWEN), 32'd1);
      check("rmo_c4_ramaddr", ramaddr, 32'h600);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (!dwait) got = 1;
         step(); @(negedge CLK);
      end
      dWEN = 0;
      check("rmo_regrant_done", 32'(got), 32'd1);

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
